// File: rtl/grid_arbiter_if.sv
// grid_arbiter_if: requester-side bus of the grid RAM arbiter
// Ports (as signals): req/req_x/req_y/req_we/req_wdata carry the three packed requests,
// excl_en/excl_sel control exclusive mode, gnt/rvalid/rdata/busy report back.
// Modports: slave = arbiter side, master = requester side.
interface grid_arbiter_if #(
  parameter int X_W = 6,
  parameter int Y_W = 5,
  parameter int D_W = 3
);
  logic [2:0]       req;
  logic [3*X_W-1:0] req_x;
  logic [3*Y_W-1:0] req_y;
  logic             req_we;
  logic [D_W-1:0]   req_wdata;
  logic             excl_en;
  logic [1:0]       excl_sel;
  logic [2:0]       gnt;
  logic [2:0]       rvalid;
  logic [D_W-1:0]   rdata;
  logic             busy;
  modport slave (
    input  req, req_x, req_y, req_we, req_wdata, excl_en, excl_sel,
    output gnt, rvalid, rdata, busy
  );
  modport master (
    output req, req_x, req_y, req_we, req_wdata, excl_en, excl_sel,
    input  gnt, rvalid, rdata, busy
  );
endinterface

// File: rtl/grid_arbiter.sv
// grid_arbiter: per-cycle round-robin sharing of the single-port grid RAM among three requesters
// Ports: clock, reset (sync, active-high); bus = requester interface (slave side);
// grid_x/grid_y/grid_write/grid_in drive the RAM, grid_out is its registered read data.
module grid_arbiter #(
  parameter int X_W = 6,
  parameter int Y_W = 5,
  parameter int D_W = 3
) (
  input  logic           clock,
  input  logic           reset,
  grid_arbiter_if.slave  bus,
  output logic [X_W-1:0] grid_x,
  output logic [Y_W-1:0] grid_y,
  output logic           grid_write,
  output logic [D_W-1:0] grid_in,
  input  logic [D_W-1:0] grid_out
);
  logic [1:0] ptr, c1, c2, g;
  logic [2:0] elig;
  logic       have;
  // reset blocks every grant so no RAM write can happen in a reset cycle
  assign elig = reset ? 3'b000 :
                !bus.excl_en ? bus.req :
                bus.excl_sel == 2'd3 ? 3'b000 : bus.req & (3'b001 << bus.excl_sel);
  assign c1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
  assign c2 = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
  assign g = elig[ptr] ? ptr : elig[c1] ? c1 : c2;
  assign have = |elig;
  assign bus.gnt = have ? 3'b001 << g : 3'b000;
  assign grid_x = have ? bus.req_x[g*X_W +: X_W] : '0;
  assign grid_y = have ? bus.req_y[g*Y_W +: Y_W] : '0;
  // only the loader (port 0) may write
  assign grid_write = have && g == 2'd0 && bus.req_we;
  assign grid_in = have && g == 2'd0 ? bus.req_wdata : '0;
  assign bus.rdata = grid_out;
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= 2'd0;
      bus.rvalid <= 3'b000;
      bus.busy <= 1'b0;
    end else begin
      if (have) ptr <= g == 2'd2 ? 2'd0 : g + 2'd1;
      bus.rvalid <= grid_write ? 3'b000 : bus.gnt;
      bus.busy <= have;
    end
  end
endmodule
